// File: rtl/lc3_io_pkg.sv
// ============================================================================
//  Module      : lc3_io_pkg
//  Description : Shared LC-3 memory-mapped I/O types and constants.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lc3_io_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DSR_READY = 15;
  localparam int DSR_OVR   = 14;

  localparam logic [15:0] KBSR = 16'hFE00;
  localparam logic [15:0] KBDR = 16'hFE02;
  localparam logic [15:0] DSR  = 16'hFE04;
  localparam logic [15:0] DDR  = 16'hFE06;

  localparam logic [15:0] DSR_RESET_VAL = 16'h8000;

endpackage

`default_nettype wire

// File: rtl/lc3_baud_tick.sv
// ============================================================================
//  Module      : lc3_baud_tick
//  Description : Loadable bit-period down-counter; ticks while the count is 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lc3_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_tick
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] c_reload = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= c_reload;
    end else if (i_en) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_tick = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/lc3_display_out.sv
// ============================================================================
//  Module      : lc3_display_out
//  Description : LC-3 DDR consumer; serialises each character as 8N1 and
//                reports ready/overrun through the DSR.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lc3_display_out
  import lc3_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] DDR_D,
  input  logic        DDR_WE,
  output logic [15:0] DSR_Q,
  output logic        Tx
);

  tx_state_t  r_state;
  logic [7:0] r_shift;
  logic [2:0] r_bit;
  logic       r_tx;
  logic       r_ready;
  logic       r_ovr;

  logic w_tick;
  logic w_accept;
  logic w_load;
  logic w_unused_hi;

  assign w_accept    = DDR_WE & r_ready;
  assign w_load      = (r_state == IDLE) ? w_accept : w_tick;
  assign w_unused_hi = ^DDR_D[15:8];

  lc3_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk    (Clk),
    .rst_n  (Reset),
    .i_load (w_load),
    .i_en   (r_state != IDLE),
    .o_tick (w_tick)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_tx    <= 1'b1;
      r_ready <= 1'b1;
      r_ovr   <= 1'b0;
    end else begin
      // A write seen while busy is dropped but remembered as an overrun.
      if (DDR_WE && !r_ready) begin
        r_ovr <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shift <= DDR_D[7:0];
            r_ready <= 1'b0;
            r_ovr   <= 1'b0;
            r_tx    <= 1'b0;
            r_state <= START;
          end
        end
        START: begin
          if (w_tick) begin
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_tick) begin
            r_shift <= r_shift >> 1;
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_tx    <= r_shift[1];
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            r_ready <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    DSR_Q            = '0;
    DSR_Q[DSR_READY] = r_ready;
    DSR_Q[DSR_OVR]   = r_ovr;
  end

  assign Tx = r_tx;

endmodule

`default_nettype wire

// File: doc/lc3_display_out.md
# lc3_display_out

Display-side consumer of the LC-3 Display Data Register (DDR). When the CPU writes the DDR, the block latches the character and serialises it on a UART-style line: 1 start bit, 8 data bits, 1 stop bit. While a frame is in flight it drives the Display Status Register (DSR) busy. It sits beside the memory-mapped I/O decode and is the reader of the DDR/DSR pair.

## Interface
Parameters:
- CLKS_PER_BIT, 16 — clock cycles per serial bit; legal range ≥ 2.

Ports:
- Clk  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-low reset (sampled on the rising edge of Clk).
- DDR_D  in  16  write data for the DDR; only [7:0] is used.
- DDR_WE  in  1  one-cycle write strobe for the DDR from the I/O decode.
- DSR_Q  out  16  DSR read value:
  - [15] ready
  - [14] overrun (sticky)
  - [13:0] always 0
- Tx  out  1  serial output; idles high.

## Operation
- FSM states: IDLE, START, DATA, STOP.
- Reset (Reset=0 at an edge) forces:
  - state IDLE, Tx=1, DSR_Q=16'h8000
  - bit counter 0, baud counter 0, shift register 0
  - Reset wins over a simultaneous DDR_WE.
- IDLE:
  - If DDR_WE=1, then:
    - shift ← DDR_D[7:0]
    - DSR[15] ← 0
    - DSR[14] ← 0
    - baud ← CLKS_PER_BIT-1
    - go to START
  - DDR_D[15:8] is ignored.
- START:
  - Tx=0.
  - When baud=0: baud ← CLKS_PER_BIT-1, bit ← 0, go to DATA.
- DATA:
  - Tx=shift[0], sent LSB first.
  - When baud=0: shift right, bit ← bit+1, reload baud.
  - After bit 7 completes, go to STOP.
- STOP:
  - Tx=1.
  - When baud=0: DSR[15] ← 1, go to IDLE.
- Otherwise, in every state, baud decrements by 1 each cycle.
- Write while busy (DSR[15]=0, registered value), including the final STOP cycle:
  - The character is dropped.
  - DSR[14] ← 1.
  - The frame in progress is unaffected.
- DSR[14] clears only on reset or on the next accepted write.
- DSR_Q is a register output, not derived combinationally from state.
- Reset mid-frame aborts the frame: Tx=1 from the next cycle; the partial character is lost.

## Timing
- DDR_WE sampled at edge k:
  - Tx=0 and DSR[15]=0 visible after edge k.
  - Start bit occupies cycles k+1 … k+CLKS_PER_BIT.
- Data bit n occupies cycles k+1+(n+1)·CLKS_PER_BIT … k+(n+2)·CLKS_PER_BIT.
- Stop bit ends at edge k+10·CLKS_PER_BIT; DSR[15]=1 is visible after that edge.
- A write at edge k+10·CLKS_PER_BIT+1 or later is accepted, giving a back-to-back frame with no idle gap beyond one cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package lc3_io_pkg holds:
  - state enum (IDLE, START, DATA, STOP)
  - DSR bit indices (DSR_READY=15, DSR_OVR=14)
  - memory-map constants KBSR=16'hFE00, KBDR=16'hFE02, DSR=16'hFE04, DDR=16'hFE06
  - DSR reset value 16'h8000
- One sub-module, lc3_baud_tick:
  - down-counter of width $clog2(CLKS_PER_BIT)
  - load and enable inputs; tick output when the count is 0
  - reused later by the keyboard receiver.

## Test plan
- Reset then idle: Reset=0 for 2 cycles, release → DSR_Q=16'h8000, Tx=1 held for 100 cycles.
- Single frame, CLKS_PER_BIT=16, write DDR_D=16'hAB41 → Tx sequence 0,1,0,0,0,0,0,1,0,1, each bit 16 cycles. DSR_Q=16'h0000 for 160 cycles, then 16'h8000.
- Overrun: write 16'h0055, then write 16'h0066 at cycle 50 → line carries only 0x55. DSR_Q=16'h4000 during the frame, 16'hC000 after it. The next write of 16'h0033 clears DSR_Q[14].
- Back-to-back: write 16'h00FF, then write 16'h0000 one cycle after DSR[15] returns to 1 → second start bit begins with no dropped bits and no overrun.
- Reset mid-frame: write 16'h00A5, assert Reset at cycle 70 → Tx=1 on the next cycle, DSR_Q=16'h8000, no further transitions on Tx.
- Reset/write collision: Reset=0 and DDR_WE=1 on the same edge → no frame starts, DSR_Q=16'h8000.
